// File: rtl/square_pkg.sv
// ----------------------------------------------------------------------------
// square_pkg
// Shared definitions for the sequential squarer and its BCD converter.
//   state_t      : control states of square_finder
//   DEFAULT_*    : default operand width and BCD digit count
//   bcdAdjust()  : double-dabble digit correction (+3 when digit >= 5)
// ----------------------------------------------------------------------------
package square_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_DIGITS = 5;

  localparam logic [3:0] BCD_ADJUST_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_ADJUST           = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    CONVERT,
    DONE
  } state_t;

  // A digit of 5 or more would become >= 10 after the next left shift,
  // so it is pre-corrected by +3 to carry into the next digit instead.
  function automatic logic [3:0] bcdAdjust(input logic [3:0] digit);
    return (digit >= BCD_ADJUST_THRESHOLD) ? digit + BCD_ADJUST : digit;
  endfunction

endpackage

// File: rtl/binary_to_bcd_sequential.sv
// ----------------------------------------------------------------------------
// binary_to_bcd_sequential
// Clocked double-dabble converter, one bit per clock.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   i_load       : capture i_bin and begin a conversion (IN_WIDTH cycles)
//   i_bin        : unsigned binary value to convert
//   o_done       : high during the cycle whose rising edge completes the
//                  conversion (combinational, one cycle wide)
//   o_bcd        : packed BCD result, valid while o_done is high
// ----------------------------------------------------------------------------
module binary_to_bcd_sequential
  import square_pkg::*;
#(
  parameter int IN_WIDTH = 2 * DEFAULT_WIDTH,
  parameter int DIGITS   = DEFAULT_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [IN_WIDTH-1:0]   i_bin,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CW = $clog2(IN_WIDTH + 1);

  logic [IN_WIDTH-1:0] r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CW-1:0]       r_count;
  logic                r_active;

  logic [4*DIGITS-1:0] w_adjusted;
  logic [4*DIGITS-1:0] w_bcdShifted;
  logic                w_lastStep;

  // Correct every digit before the shift of this step.
  always_comb begin
    w_adjusted = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      w_adjusted[4*d +: 4] = bcdAdjust(r_bcd[4*d +: 4]);
    end
  end

  // The top bit of the BCD field falls off; DIGITS is sized so it is always 0.
  assign w_bcdShifted = (w_adjusted << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[IN_WIDTH-1]};
  assign w_lastStep   = r_active && (r_count == CW'(IN_WIDTH - 1));

  assign o_done = w_lastStep;
  assign o_bcd  = w_bcdShifted;

  // Shift register and step counter; load takes priority over stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_count  <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd    <= w_bcdShifted;
      r_bin    <= r_bin << 1;
      r_count  <= r_count + CW'(1);
      if (w_lastStep) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/square_finder.sv
// ----------------------------------------------------------------------------
// square_finder
// Sequential squarer: shift-and-add multiply of alpha by itself (WIDTH
// cycles) followed by a sequential binary-to-BCD conversion (2*WIDTH cycles).
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   start          : request a new square; honoured only in IDLE
//   alpha          : unsigned operand, captured when start is accepted
//   busy           : high in MULTIPLY and CONVERT
//   done           : one-cycle pulse when square/square_decimal update
//   square         : registered 2*WIDTH-bit product
//   square_decimal : registered packed BCD of square, digit 0 in [3:0]
// ----------------------------------------------------------------------------
module square_finder
  import square_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     alpha,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   square,
  output logic [4*DIGITS-1:0]  square_decimal
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_nextState;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;

  logic [2*WIDTH-1:0]   w_accNext;
  logic                 w_accept;
  logic                 w_loadConv;
  logic                 w_capture;
  logic                 w_convDone;
  logic [4*DIGITS-1:0]  w_convBcd;

  assign w_accNext = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. The converter is loaded with w_accNext so
  // the final multiply step and the converter load share the same edge.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_loadConv  = 1'b0;
    w_capture   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = MULTIPLY;
        end
      end
      MULTIPLY: begin
        busy = 1'b1;
        if (r_count == CW'(WIDTH - 1)) begin
          w_loadConv  = 1'b1;
          w_nextState = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (w_convDone) begin
          w_capture   = 1'b1;
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Shift-and-add multiplier datapath; the accumulator holds the product
  // through CONVERT so it can be published alongside the BCD result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, alpha};
      r_mplier <= alpha;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == MULTIPLY) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
    end
  end

  // Published results change only on the edge entering DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      square         <= '0;
      square_decimal <= '0;
    end else if (w_capture) begin
      square         <= r_acc;
      square_decimal <= w_convBcd;
    end
  end

  binary_to_bcd_sequential #(
    .IN_WIDTH (2 * WIDTH),
    .DIGITS   (DIGITS)
  ) u_bcd (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_loadConv),
    .i_bin  (w_accNext),
    .o_done (w_convDone),
    .o_bcd  (w_convBcd)
  );

endmodule

// File: tb/tb_square_finder.sv
// ----------------------------------------------------------------------------
// tb_square_finder
// Self-checking bench for square_finder. Expected results are queued when a
// start is driven and compared whenever the DUT pulses done.
// ----------------------------------------------------------------------------
module tb_square_finder;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  alpha;
  logic        busy;
  logic        done;
  logic [15:0] square;
  logic [19:0] square_decimal;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [35:0] expQ[$];
  logic [15:0] lastSquare;
  logic [19:0] lastDecimal;

  square_finder dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .alpha          (alpha),
    .busy           (busy),
    .done           (done),
    .square         (square),
    .square_decimal (square_decimal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference decimal conversion by repeated division.
  function automatic logic [19:0] toBcd(input int value);
    logic [19:0] result;
    int          v;
    result = '0;
    v      = value;
    for (int d = 0; d < 5; d++) begin
      result[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return result;
  endfunction

  // Scoreboard consumer plus the busy/done exclusivity check.
  always @(negedge clock) begin
    logic [35:0] exp;
    if (busy && done) checkOutput("busyDoneOverlap", 32'd1, 32'd0);
    if (done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("square", 32'(square), 32'(exp[35:20]));
        checkOutput("squareDecimal", 32'(square_decimal), 32'(exp[19:0]));
      end
    end
  end

  // Drives one operation from IDLE and checks its timing. With
  // pulseIgnored set, start is re-pulsed with alpha=200 mid-operation.
  task automatic applyStimulus(input logic [7:0] a, input bit pulseIgnored);
    int ai;
    int k;
    int doneAt;
    int busyCycles;
    ai         = int'(a);
    alpha      = a;
    start      = 1'b1;
    expQ.push_back({16'(ai * ai), toBcd(ai * ai)});
    k          = 0;
    doneAt     = 0;
    busyCycles = 0;
    while (doneAt == 0 && k < 60) begin
      @(negedge clock);
      k++;
      if (busy) busyCycles++;
      if (done) doneAt = k;
      if (pulseIgnored && k == 24) begin
        checkOutput("holdSquare", 32'(square), 32'(lastSquare));
        checkOutput("holdDecimal", 32'(square_decimal), 32'(lastDecimal));
      end
      if (pulseIgnored && (k == 3 || k == 20)) begin
        start = 1'b1;
        alpha = 8'd200;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("latency", 32'(doneAt), 32'd25);
    checkOutput("busyCycles", 32'(busyCycles), 32'd24);
    @(negedge clock);
    checkOutput("donePulseWidth", 32'(done), 32'd0);
    lastSquare  = 16'(ai * ai);
    lastDecimal = toBcd(ai * ai);
  endtask

  initial begin
    int k;
    int dones;
    int lastDone;

    reset       = 1'b1;
    start       = 1'b0;
    alpha       = 8'd0;
    lastSquare  = 16'd0;
    lastDecimal = 20'd0;

    // Reset state.
    repeat (2) @(negedge clock);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetSquare", 32'(square), 32'd0);
    checkOutput("resetDecimal", 32'(square_decimal), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed values, including the largest product and top digit.
    applyStimulus(8'd0, 1'b0);
    applyStimulus(8'd15, 1'b0);
    applyStimulus(8'd255, 1'b0);
    applyStimulus(8'd100, 1'b0);

    // Starts during MULTIPLY and CONVERT must be dropped.
    applyStimulus(8'd12, 1'b1);
    repeat (30) @(negedge clock);

    // Reset mid-operation discards the result.
    alpha = 8'd99;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetDone", 32'(done), 32'd0);
    checkOutput("midResetSquare", 32'(square), 32'd0);
    checkOutput("midResetDecimal", 32'(square_decimal), 32'd0);
    lastSquare  = 16'd0;
    lastDecimal = 20'd0;
    repeat (40) @(negedge clock);
    applyStimulus(8'd7, 1'b0);

    // start held high: a new operation every 26 cycles.
    alpha = 8'd3;
    start = 1'b1;
    repeat (3) expQ.push_back({16'd9, toBcd(9)});
    k        = 0;
    dones    = 0;
    lastDone = 0;
    while (dones < 3 && k < 150) begin
      @(negedge clock);
      k++;
      if (done) begin
        dones++;
        if (dones == 1) checkOutput("heldFirstLatency", 32'(k), 32'd25);
        else            checkOutput("heldPeriod", 32'(k - lastDone), 32'd26);
        lastDone = k;
      end
    end
    start = 1'b0;
    checkOutput("heldDoneCount", 32'(dones), 32'd3);
    lastSquare  = 16'd9;
    lastDecimal = toBcd(9);
    repeat (30) @(negedge clock);

    // Every operand value.
    for (int a = 0; a < 256; a++) begin
      applyStimulus(8'(a), 1'b0);
    end

    repeat (5) @(negedge clock);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
